// File: rtl/psum_channel_accumulator_pkg.sv
// Shared definitions for the partial-sum channel accumulator.
// Holds the datapath dimensions, the controller state encoding and the
// saturating accumulate helper used by every lane.
package psum_channel_accumulator_pkg;

  localparam int FILTER_NUM = 32;   // filters (lanes) per beat
  localparam int IN_W       = 8;    // signed partial-sum width per lane
  localparam int ACC_W      = 16;   // signed accumulator width per lane
  localparam int MAX_COL    = 256;  // depth of the per-column buffer
  localparam int OUT_W      = 8;    // unsigned activation width per lane
  localparam int COL_AW     = $clog2(MAX_COL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Signed a + sext(b), clamped to the ACC_W signed range.
  // Overflow shows up as a mismatch between the two top bits of the
  // one-bit-wider sum; the top bit then tells which rail to clamp to.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [IN_W-1:0]  b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, {(ACC_W - 1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(ACC_W - 1){1'b1}}};
      end
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/psum_channel_accumulator_requant_lane.sv
// requant_lane: combinational datapath for one filter lane.
//   i_base  : running accumulator for this column (zero on group 0)
//   i_ps    : signed partial sum of the current beat
//   i_shift : requantization right-shift amount
//   o_sum   : saturated base + sext(ps), written back to the buffer
//   o_act   : ReLU + round-half-up shift + clamp to 0..255 of o_sum
module requant_lane
  import psum_channel_accumulator_pkg::*;
(
  input  logic [ACC_W-1:0] i_base,
  input  logic [IN_W-1:0]  i_ps,
  input  logic [3:0]       i_shift,
  output logic [ACC_W-1:0] o_sum,
  output logic [OUT_W-1:0] o_act
);

  logic [ACC_W-1:0] w_sum;
  logic [ACC_W:0]   w_half;
  logic [ACC_W:0]   w_shifted;

  assign w_sum = sat_add(i_base, i_ps);
  assign o_sum = w_sum;

  // Half-LSB rounding constant for the selected shift (none for shift 0)
  always_comb begin
    w_half = {(ACC_W + 1){1'b0}};
    if (i_shift != 4'd0) begin
      w_half = {{ACC_W{1'b0}}, 1'b1} << (i_shift - 4'd1);
    end else begin
      w_half = {(ACC_W + 1){1'b0}};
    end
  end

  // ReLU, rounded shift and clamp; the sum is only used when positive,
  // so a logical shift on the one-bit-wider value is exact here
  always_comb begin
    w_shifted = ({1'b0, w_sum} + w_half) >> i_shift;
    if (w_sum[ACC_W-1] || (w_sum == {ACC_W{1'b0}})) begin
      o_act = {OUT_W{1'b0}};
    end else if (|w_shifted[ACC_W:OUT_W]) begin
      o_act = {OUT_W{1'b1}};
    end else begin
      o_act = w_shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_channel_accumulator.sv
// psum_channel_accumulator: accumulates per-filter partial sums over all
// input-channel groups of an output row in a per-column buffer, then
// requantizes the last group to 8-bit activations.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, cfg_*          : layer start pulse and geometry/shift config
//   in_valid/in_ready     : partial_sum beat handshake
//   partial_sum           : FILTER_NUM signed IN_W lanes, lane k at [(k+1)*IN_W-1 -: IN_W]
//   out_valid/out_ready   : activation handshake (single output register)
//   out_data/out_col/out_row : activations with their pixel coordinates
//   busy, frame_done      : not-idle flag, end-of-layer pulse
module psum_channel_accumulator
  import psum_channel_accumulator_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [8:0]                  cfg_cols,
  input  logic [8:0]                  cfg_rows,
  input  logic [3:0]                  cfg_groups,
  input  logic [3:0]                  cfg_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FILTER_NUM*IN_W-1:0]  partial_sum,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FILTER_NUM*OUT_W-1:0] out_data,
  output logic [8:0]                  out_col,
  output logic [8:0]                  out_row,
  output logic                        busy,
  output logic                        frame_done
);

  state_e r_state;
  state_e w_next_state;

  logic [8:0] r_cols;
  logic [8:0] r_rows;
  logic [3:0] r_groups;
  logic [3:0] r_shift;
  logic [8:0] r_col;
  logic [3:0] r_grp;
  logic [8:0] r_row;

  logic                        r_out_valid;
  logic [FILTER_NUM*OUT_W-1:0] r_out_data;
  logic [8:0]                  r_out_col;
  logic [8:0]                  r_out_row;
  logic                        r_frame_done;

  logic [FILTER_NUM*ACC_W-1:0] r_acc [MAX_COL];

  logic                        w_in_ready;
  logic                        w_busy;
  logic                        w_accept;
  logic                        w_drain;
  logic                        w_last_col;
  logic                        w_last_grp;
  logic                        w_last_row;
  logic [FILTER_NUM*ACC_W-1:0] w_acc_rd;
  logic [FILTER_NUM*ACC_W-1:0] w_base;
  logic [FILTER_NUM*ACC_W-1:0] w_sum;
  logic [FILTER_NUM*OUT_W-1:0] w_act;

  assign w_last_col = (r_col == (r_cols - 9'd1));
  assign w_last_grp = (r_grp == (r_groups - 4'd1));
  assign w_last_row = (r_row == (r_rows - 9'd1));
  // Output register is free this cycle, either empty or handing off now
  assign w_drain    = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // Group 0 starts a fresh sum, so the stale buffer entry is never read
  assign w_acc_rd = r_acc[r_col[COL_AW-1:0]];
  assign w_base   = (r_grp == 4'd0) ? {(FILTER_NUM * ACC_W){1'b0}} : w_acc_rd;

  for (genvar k = 0; k < FILTER_NUM; k++) begin : g_lane
    requant_lane u_lane (
      .i_base  (w_base[(k+1)*ACC_W-1 -: ACC_W]),
      .i_ps    (partial_sum[(k+1)*IN_W-1 -: IN_W]),
      .i_shift (r_shift),
      .o_sum   (w_sum[(k+1)*ACC_W-1 -: ACC_W]),
      .o_act   (w_act[(k+1)*OUT_W-1 -: OUT_W])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && w_last_col && w_last_grp && w_last_row) begin
          w_next_state = ST_FLUSH;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_drain) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FLUSH;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs; last-group beats need room in the output register
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last_grp) begin
          w_in_ready = w_drain;
        end else begin
          w_in_ready = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // Config latch, beat counters, output register and end-of-layer pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cols       <= 9'd0;
      r_rows       <= 9'd0;
      r_groups     <= 4'd0;
      r_shift      <= 4'd0;
      r_col        <= 9'd0;
      r_grp        <= 4'd0;
      r_row        <= 9'd0;
      r_out_valid  <= 1'b0;
      r_out_data   <= {(FILTER_NUM * OUT_W){1'b0}};
      r_out_col    <= 9'd0;
      r_out_row    <= 9'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_FLUSH) && w_drain;

      if ((r_state == ST_IDLE) && start) begin
        r_cols   <= cfg_cols;
        r_rows   <= cfg_rows;
        r_groups <= cfg_groups;
        r_shift  <= cfg_shift;
        r_col    <= 9'd0;
        r_grp    <= 4'd0;
        r_row    <= 9'd0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= 9'd0;
          if (w_last_grp) begin
            r_grp <= 4'd0;
            r_row <= r_row + 9'd1;
          end else begin
            r_grp <= r_grp + 4'd1;
          end
        end else begin
          r_col <= r_col + 9'd1;
        end
      end

      // A last-group beat reloads in the same edge as a handoff
      if (w_accept && w_last_grp) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_act;
        r_out_col   <= r_col;
        r_out_row   <= r_row;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Per-column accumulation buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc[r_col[COL_AW-1:0]] <= w_sum;
    end
  end

  assign in_ready   = w_in_ready;
  assign busy       = w_busy;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_col    = r_out_col;
  assign out_row    = r_out_row;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_psum_channel_accumulator.sv
// Self-checking bench for psum_channel_accumulator: a table of single-beat
// layers for the requantization arithmetic, plus hand-written multi-beat
// sequences for accumulation, backpressure, ordering and reset.
module tb_psum_channel_accumulator;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [8:0]   cfg_cols = 9'd1;
  logic [8:0]   cfg_rows = 9'd1;
  logic [3:0]   cfg_groups = 4'd1;
  logic [3:0]   cfg_shift = 4'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] partial_sum = 256'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic [8:0]   out_col;
  logic [8:0]   out_row;
  logic         busy;
  logic         frame_done;

  psum_channel_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_cols    (cfg_cols),
    .cfg_rows    (cfg_rows),
    .cfg_groups  (cfg_groups),
    .cfg_shift   (cfg_shift),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .partial_sum (partial_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_col     (out_col),
    .out_row     (out_row),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  logic [255:0] q_data[$];
  int q_col[$];
  int q_row[$];
  int q_cyc[$];

  typedef struct {
    logic [7:0] ps;
    logic [3:0] shift;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[13];

  // Output monitor: records every handoff and every frame_done cycle
  always begin
    @(negedge clk);
    cyc++;
    #2;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_col.push_back(int'(out_col));
      q_row.push_back(int'(out_row));
      q_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [255:0] mk(input logic [7:0] l0, input logic [7:0] l5,
                                      input logic [7:0] l31);
    logic [255:0] v;
    v = 256'd0;
    v[7:0]     = l0;
    v[47:40]   = l5;
    v[255:248] = l31;
    return v;
  endfunction

  // Called at a falling edge; leaves the DUT in RUN one cycle later
  task automatic start_layer(input logic [8:0] cols, input logic [8:0] rows,
                             input logic [3:0] groups, input logic [3:0] shift);
    cfg_cols   = cols;
    cfg_rows   = rows;
    cfg_groups = groups;
    cfg_shift  = shift;
    start      = 1'b1;
    q_data.delete();
    q_col.delete();
    q_row.delete();
    q_cyc.delete();
    fd_count   = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send_beat(input logic [255:0] ps);
    int n;
    in_valid    = 1'b1;
    partial_sum = ps;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", {255'd0, busy}, 256'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{8'h05, 4'd0,  8'd5};
    tbl[1]  = '{8'hFD, 4'd0,  8'd0};
    tbl[2]  = '{8'h80, 4'd0,  8'd0};
    tbl[3]  = '{8'h00, 4'd0,  8'd0};
    tbl[4]  = '{8'h7F, 4'd1,  8'd64};
    tbl[5]  = '{8'h7F, 4'd2,  8'd32};
    tbl[6]  = '{8'h64, 4'd3,  8'd13};
    tbl[7]  = '{8'h01, 4'd1,  8'd1};
    tbl[8]  = '{8'h01, 4'd2,  8'd0};
    tbl[9]  = '{8'h03, 4'd2,  8'd1};
    tbl[10] = '{8'h64, 4'd7,  8'd1};
    tbl[11] = '{8'h7F, 4'd15, 8'd0};
    tbl[12] = '{8'h7F, 4'd0,  8'd127};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
    chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_out_data", out_data, 256'd0);
    chk("rst_out_col", {247'd0, out_col}, 256'd0);
    chk("rst_out_row", {247'd0, out_row}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_frame_done", {255'd0, frame_done}, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat layers: requantization arithmetic per table entry
    for (int i = 0; i < 13; i++) begin
      start_layer(9'd1, 9'd1, 4'd1, tbl[i].shift);
      send_beat(rep(tbl[i].ps));
      wait_done();
      chk($sformatf("tbl%0d_count", i), q_data.size(), 256'd1);
      if (q_data.size() > 0) chk($sformatf("tbl%0d_data", i), q_data[0], rep(tbl[i].exp));
      chk($sformatf("tbl%0d_fd", i), fd_count, 256'd1);
    end

    // Reset in the middle of a layer
    start_layer(9'd4, 9'd1, 4'd2, 4'd0);
    for (int i = 0; i < 3; i++) send_beat(rep(8'd9));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mrst_busy", {255'd0, busy}, 256'd0);
    chk("mrst_out_data", out_data, 256'd0);
    chk("mrst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("mrst_in_ready", {255'd0, in_ready}, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_layer(9'd2, 9'd1, 4'd1, 4'd0);
    send_beat(rep(8'd7));
    send_beat(rep(8'd8));
    wait_done();
    chk("mrst_count", q_data.size(), 256'd2);
    if (q_data.size() >= 2) begin
      chk("mrst_col0", q_col[0], 256'd0);
      chk("mrst_data0", q_data[0], rep(8'd7));
      chk("mrst_col1", q_col[1], 256'd1);
      chk("mrst_data1", q_data[1], rep(8'd8));
    end

    // groups=1, two columns, ReLU on the second
    start_layer(9'd2, 9'd1, 4'd1, 4'd0);
    send_beat(rep(8'd5));
    send_beat(rep(8'hFD));
    wait_done();
    chk("g1_count", q_data.size(), 256'd2);
    if (q_data.size() >= 2) begin
      chk("g1_data0", q_data[0], rep(8'd5));
      chk("g1_col0", q_col[0], 256'd0);
      chk("g1_data1", q_data[1], rep(8'd0));
      chk("g1_col1", q_col[1], 256'd1);
      chk("g1_fd_timing", fd_cyc, q_cyc[1] + 1);
    end
    chk("g1_fd_count", fd_count, 256'd1);

    // Three groups with rounding shift 2 and a negative lane
    start_layer(9'd2, 9'd1, 4'd3, 4'd2);
    send_beat(mk(8'd10, 8'hF6, 8'd1));
    send_beat(mk(8'd0, 8'd50, 8'd0));
    send_beat(mk(8'd20, 8'hF6, 8'd1));
    send_beat(mk(8'd0, 8'd50, 8'd0));
    send_beat(mk(8'd7, 8'hF6, 8'd1));
    send_beat(mk(8'd0, 8'd50, 8'd0));
    wait_done();
    chk("g3_count", q_data.size(), 256'd2);
    if (q_data.size() >= 2) begin
      chk("g3_col0_data", q_data[0], mk(8'd9, 8'd0, 8'd1));
      chk("g3_col1_data", q_data[1], mk(8'd0, 8'd38, 8'd0));
    end

    // Fifteen groups of 127: clamp at shift 0, rounded at shift 3
    start_layer(9'd1, 9'd1, 4'd15, 4'd0);
    for (int i = 0; i < 15; i++) send_beat(rep(8'd127));
    wait_done();
    chk("sat_count", q_data.size(), 256'd1);
    if (q_data.size() > 0) chk("sat_data", q_data[0], rep(8'd255));
    start_layer(9'd1, 9'd1, 4'd15, 4'd3);
    for (int i = 0; i < 15; i++) send_beat(rep(8'd127));
    wait_done();
    if (q_data.size() > 0) chk("sat_shift3_data", q_data[0], rep(8'd238));

    // Backpressure on the last group
    start_layer(9'd3, 9'd1, 4'd1, 4'd0);
    out_ready = 1'b0;
    send_beat(rep(8'd1));
    #1;
    chk("bp_out_valid", {255'd0, out_valid}, 256'd1);
    chk("bp_in_ready", {255'd0, in_ready}, 256'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_hold_data", out_data, rep(8'd1));
    chk("bp_hold_col", {247'd0, out_col}, 256'd0);
    chk("bp_hold_in_ready", {255'd0, in_ready}, 256'd0);
    @(negedge clk);
    out_ready = 1'b1;
    send_beat(rep(8'd2));
    send_beat(rep(8'd3));
    wait_done();
    chk("bp_count", q_data.size(), 256'd3);
    if (q_data.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_data%0d", i), q_data[i], rep(8'(i + 1)));
        chk($sformatf("bp_col%0d", i), q_col[i], i);
      end
      chk("bp_back_to_back1", q_cyc[1], q_cyc[0] + 1);
      chk("bp_back_to_back2", q_cyc[2], q_cyc[1] + 1);
    end
    chk("bp_fd_count", fd_count, 256'd1);

    // Row/column ordering, with a start pulse ignored during RUN
    start_layer(9'd3, 9'd2, 4'd2, 4'd0);
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < 2; g++) begin
        for (int c = 0; c < 3; c++) begin
          if (g == 0) send_beat(mk(8'd1, 8'd0, 8'd0));
          else send_beat(mk(8'((r * 3 + c) * 10), 8'd0, 8'd0));
          if (r == 0 && g == 0 && c == 0) begin
            cfg_cols = 9'd1;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
            cfg_cols = 9'd3;
          end
        end
      end
    end
    wait_done();
    chk("ord_count", q_data.size(), 256'd6);
    if (q_data.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("ord_row%0d", i), q_row[i], i / 3);
        chk($sformatf("ord_col%0d", i), q_col[i], i % 3);
        chk($sformatf("ord_data%0d", i), q_data[i], mk(8'(i * 10 + 1), 8'd0, 8'd0));
      end
    end
    chk("ord_fd_count", fd_count, 256'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
